// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the riscv32 multicycle control unit:
// state encoding, ALU operations, opcodes, mux selects and the per-state output table.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALUWB     = 4'd8,
        S_LUI       = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR_CALC = 4'd12,
        S_JALR_JMP  = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] SRCB_ZERO  = 2'b11;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [1:0] alu_srca;
        logic [1:0] alu_srcb;
        logic       reg_write;
        logic       illegal;
    } ctrl_out_t;

    // Moore outputs of a state; the branch PC load is added outside since it depends on flags.
    function automatic ctrl_out_t state_outputs(input state_t s, input logic [3:0] exec_op);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.ir_write   = 1'b1;
                o.pc_write   = 1'b1;
                o.alu_srca   = SRCA_PC;
                o.alu_srcb   = SRCB_FOUR;
                o.result_src = RES_ALURESULT;
            end
            S_DECODE:    begin o.alu_srca = SRCA_OLDPC; o.alu_srcb = SRCB_IMM; end
            S_MEMADR:    begin o.alu_srca = SRCA_RD1;   o.alu_srcb = SRCB_IMM; end
            S_MEMREAD:   begin o.adr_src = 1'b1; o.result_src = RES_ALUOUT; end
            S_MEMWB:     begin o.result_src = RES_DATA; o.reg_write = 1'b1; end
            S_MEMWRITE:  begin o.adr_src = 1'b1; o.result_src = RES_ALUOUT; o.mem_write = 1'b1; end
            S_EXEC_R:    begin o.alu_srca = SRCA_RD1; o.alu_srcb = SRCB_RD2; o.alu_control = exec_op; end
            S_EXEC_I:    begin o.alu_srca = SRCA_RD1; o.alu_srcb = SRCB_IMM; o.alu_control = exec_op; end
            S_ALUWB:     begin o.result_src = RES_ALUOUT; o.reg_write = 1'b1; end
            S_LUI:       begin o.alu_srca = SRCA_ZERO; o.alu_srcb = SRCB_IMM; end
            S_BRANCH:    begin o.alu_srca = SRCA_RD1; o.alu_srcb = SRCB_RD2; o.alu_control = ALU_SUB; end
            S_JAL:       begin o.alu_srca = SRCA_OLDPC; o.alu_srcb = SRCB_FOUR; o.pc_write = 1'b1; end
            S_JALR_CALC: begin o.alu_srca = SRCA_RD1; o.alu_srcb = SRCB_IMM; end
            S_JALR_JMP:  begin o.alu_srca = SRCA_OLDPC; o.alu_srcb = SRCB_FOUR; o.pc_write = 1'b1; end
            S_TRAP:      o.illegal = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

    // carry = 1 means rs1 >= rs2 unsigned (subtraction without borrow)
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                          input logic c, input logic v);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n ^ v;
            3'b101:  return !(n ^ v);
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction-field, flag and control bundle between the datapath (master) and the control FSM (slave).
interface multicycle_ctrl_fsm_if #(parameter int COUNT_W = 32);
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               negative;
    logic               carryout;
    logic               overflow;
    logic               pc_write;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         ResultSrc;
    logic [3:0]         ALUControl;
    logic [1:0]         ALUSrca;
    logic [1:0]         ALUSrcb;
    logic               RegWrite;
    logic [3:0]         state_out;
    logic               illegal;
    logic [COUNT_W-1:0] instr_retired;

    modport master (
        output opcode, funct3, funct7b5, zero, negative, carryout, overflow,
        input  pc_write, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrca, ALUSrcb, RegWrite, state_out, illegal, instr_retired
    );

    modport slave (
        input  opcode, funct3, funct7b5, zero, negative, carryout, overflow,
        output pc_write, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrca, ALUSrcb, RegWrite, state_out, illegal, instr_retired
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation; SUB only for R-type, SRA for either type with funct7b5.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [3:0] alu_control_o
);
    always_comb begin
        alu_control_o = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control_o = ALU_SLL;
            3'b010:  alu_control_o = ALU_SLT;
            3'b011:  alu_control_o = ALU_SLTU;
            3'b100:  alu_control_o = ALU_XOR;
            3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control_o = ALU_OR;
            3'b111:  alu_control_o = ALU_AND;
            default: alu_control_o = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle riscv32 control unit: sequences FETCH/DECODE/EXECUTE/WRITEBACK and drives datapath controls.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_fsm_if.slave bus
);
    state_t             state_q, state_d;
    ctrl_out_t          outs_q;
    logic [COUNT_W-1:0] retired_q;
    logic [3:0]         exec_op;
    logic               taken;

    alu_decoder u_alu_dec (
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .is_rtype_i    (bus.opcode == OP_RTYPE),
        .alu_control_o (exec_op)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_CALC;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI, S_JAL, S_JALR_JMP: state_d = S_ALUWB;
            S_JALR_CALC: state_d = S_JALR_JMP;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Outputs are registered from the next state so they track state_q with no decode delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            outs_q    <= state_outputs(S_FETCH, ALU_ADD);
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= state_outputs(state_d, exec_op);
            if (state_d == S_FETCH) begin
                retired_q <= retired_q + COUNT_W'(1);
            end
        end
    end

    assign taken = branch_taken(bus.funct3, bus.zero, bus.negative, bus.carryout, bus.overflow);

    // Reset gates every output so no enable can fire while reset is held low.
    assign bus.pc_write      = reset & (outs_q.pc_write | ((state_q == S_BRANCH) & taken));
    assign bus.AdrSrc        = reset & outs_q.adr_src;
    assign bus.MemWrite      = reset & outs_q.mem_write;
    assign bus.IRWrite       = reset & outs_q.ir_write;
    assign bus.ResultSrc     = reset ? outs_q.result_src  : 2'b00;
    assign bus.ALUControl    = reset ? outs_q.alu_control : 4'b0000;
    assign bus.ALUSrca       = reset ? outs_q.alu_srca    : 2'b00;
    assign bus.ALUSrcb       = reset ? outs_q.alu_srcb    : 2'b00;
    assign bus.RegWrite      = reset & outs_q.reg_write;
    assign bus.illegal       = reset & outs_q.illegal;
    assign bus.state_out     = state_q;
    assign bus.instr_retired = retired_q;
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multicycle control unit for the riscv32 datapath. It sits directly upstream of the datapath and consumes opcode/funct fields from the instruction register and the ALU flags. It sequences FETCH/DECODE/EXECUTE/WRITEBACK states and drives every datapath select and write-enable. Supported subset: R-type ALU, I-type ALU, lw, sw, all six branches, jal, jalr, lui, auipc.

Parameters:
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
opcode  in  7  Instr[6:0]
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
zero, negative, carryout, overflow  in  1 each  ALU flags for the current srca/srcb
pc_write  out  1  PC load enable
AdrSrc  out  1  0 = PC, 1 = Result
MemWrite  out  1  memory write enable
IRWrite  out  1  latches Instr and OldPC
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUControl  out  4  ALU operation
ALUSrca  out  2  00 = PC, 01 = OldPC, 10 = RD1_A, 11 = zero
ALUSrcb  out  2  00 = RD2 reg, 01 = ImmExt, 10 = 4, 11 = zero
RegWrite  out  1  register file write enable
state_out  out  4  current state encoding, for debug
illegal  out  1  high while in TRAP
instr_retired  out  COUNT_W  count of completed instructions

Behaviour:
- Moore FSM; all outputs are decoded from the state register only, except the BRANCH pc_write, which also uses the flags.
- Default for every output in every state is 0, unless the state entry below says otherwise.
- Reset low: state = FETCH, instr_retired = 0, and all outputs are forced to 0 combinationally. The first active FETCH is the first cycle after reset releases.
- Reset asserted mid-instruction aborts the instruction; no write-enable may assert during reset.
- States and actions (ALU op ADD unless stated):
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrca = 00, ALUSrcb = 10, ResultSrc = 10, pc_write = 1. Next: DECODE.
  - DECODE: ALUSrca = 01, ALUSrcb = 01, so ALUOut = OldPC + imm. Next by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_CALC
    - 0110111 -> LUI
    - 0010111 -> ALUWB (ALUOut already holds OldPC + imm)
    - any other opcode -> TRAP
  - MEMADR: ALUSrca = 10, ALUSrcb = 01. Next: MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: AdrSrc = 1, ResultSrc = 00. Next: MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1. Next: FETCH.
  - MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1. Next: FETCH.
  - EXEC_R: ALUSrca = 10, ALUSrcb = 00, ALUControl decoded from funct3/funct7b5. Next: ALUWB.
  - EXEC_I: ALUSrca = 10, ALUSrcb = 01, ALUControl decoded from funct3. funct7b5 selects SRA only when funct3 = 101; SUB is never selected. Next: ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1. Next: FETCH.
  - LUI: ALUSrca = 11, ALUSrcb = 01. Next: ALUWB.
  - BRANCH: ALUSrca = 10, ALUSrcb = 00, SUB, ResultSrc = 00, pc_write = taken. Next: FETCH.
    - Taken conditions: beq zero; bne !zero; blt n^v; bge !(n^v); bltu !carryout; bgeu carryout.
    - carryout = 1 means rs1 >= rs2 unsigned.
    - funct3 = 010 or 011 is never taken.
  - JAL: ALUSrca = 01, ALUSrcb = 10, ResultSrc = 00, pc_write = 1. Next: ALUWB, which writes OldPC + 4.
  - JALR_CALC: ALUSrca = 10, ALUSrcb = 01. Next: JALR_JMP.
  - JALR_JMP: ALUSrca = 01, ALUSrcb = 10, ResultSrc = 00, pc_write = 1. Next: ALUWB. The target bit 0 is not cleared by this block.
  - TRAP: all enables 0, illegal = 1. Stays in TRAP until reset.
- instr_retired increments by 1 on every transition into FETCH from a non-reset state. It wraps modulo 2^COUNT_W.
- Latency in cycles:
  - R/I/lui/auipc: 4 (auipc is 3)
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
  - jalr: 5

Decomposition:
- Package ctrl_pkg holds the following.
- state_t enum, 4-bit.
- ALUControl constants:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- Opcode constants.
- ALUSrca/ALUSrcb/ResultSrc select constants.
- One sub-module, alu_decoder: combinational mapping of funct3, funct7b5 and an is_rtype flag to ALUControl.

Test Plan:
- Reset low, then release: state_out = FETCH and all outputs 0 while low; first cycle after release has pc_write = 1, IRWrite = 1, ALUSrcb = 10.
- opcode 0000011 (lw): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite = 1 only in MEMWB with ResultSrc = 01; instr_retired 0 -> 1.
- opcode 0110011, funct3 000, funct7b5 = 1: ALUControl = 0001 in EXEC_R. Same fields with opcode 0010011: ALUControl = 0000.
- Branches, with opcode 1100011:
  - beq, zero = 1: pc_write = 1 in BRANCH.
  - bltu, carryout = 1: pc_write = 0.
  - blt, negative = 1, overflow = 1: pc_write = 0.
- opcode 1111111: DECODE -> TRAP, illegal = 1 held for 20 cycles, instr_retired frozen; reset low then clears it.
- Reset pulsed low during MEMWRITE: MemWrite drops to 0 immediately and state_out returns to FETCH asynchronously.
